// File: rtl/exec_ctrl.sv
// exec_ctrl: execution sequencer between the debugger front panel and the
// KAPPA3-LIGHT core. It converts run/stop, step-phase and step-instruction
// button levels into the core's per-phase `run` enable. It stops only on
// instruction boundaries, except for halt and breakpoint stops, and reports
// why execution stopped.
//
// Optional feature macro: EXEC_CTRL_BREAKPOINT_EN
//   defined   : PC breakpoint compare at the fetch phase is active
//   undefined : no breakpoint; bp_addr / bp_enable are accepted but ignored
//
// Parameters:
//   LAST_PHASE     one-hot cstate value of the final phase of an instruction
//   FIRST_PHASE    one-hot cstate value of the fetch phase
//
// Ports:
//   clock          block clock (clock2 domain)
//   reset          synchronous, active-high
//   btn_run        synchronized run/stop toggle button level
//   btn_step_phase synchronized step-one-phase button level
//   btn_step_inst  synchronized step-one-instruction button level
//   cstate [3:0]   core phase, one-hot
//   halt           core halt request (level, held until the core stops)
//   pc [31:0]      core program counter
//   bp_addr [31:0] breakpoint address
//   bp_enable      breakpoint armed
//   run            core advances one phase in each cycle this is high
//   running        high while free-running or draining to a boundary
//   stop_cause[1:0] 00 none, 01 user, 10 halt, 11 breakpoint
//   inst_count[31:0] retired instruction counter (wraps)

module exec_ctrl #(
    parameter logic [3:0] LAST_PHASE  = 4'b1000,
    parameter logic [3:0] FIRST_PHASE = 4'b0001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step_phase,
    input  logic        btn_step_inst,
    input  logic [3:0]  cstate,
    input  logic        halt,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_enable,
    output logic        run,
    output logic        running,
    output logic [1:0]  stop_cause,
    output logic [31:0] inst_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_STEP_P = 3'd3,
        S_STEP_I = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_USER  = 2'b01;
    localparam logic [1:0] CAUSE_HALT  = 2'b10;
    localparam logic [1:0] CAUSE_BREAK = 2'b11;

    // Bit positions in the packed button vectors
    localparam int BTN_RUN    = 0;
    localparam int BTN_STEP_P = 1;
    localparam int BTN_STEP_I = 2;
    localparam int NUM_BTN    = 3;

    state_t              state_reg;
    state_t              state_next;
    logic [1:0]          cause_reg;
    logic [1:0]          cause_next;
    logic                resume_reg;
    logic                resume_next;
    logic                halt_reg;
    logic [31:0]         inst_count_reg;

    logic [NUM_BTN-1:0]  btn_level;
    logic [NUM_BTN-1:0]  btn_prev_reg;
    logic [NUM_BTN-1:0]  btn_edge_reg;

    logic                run_en;
    logic                bp_hit;
    logic                retire;

    assign btn_level = {btn_step_inst, btn_step_phase, btn_run};

    // ------------------------------------------------------------------
    // Registered rising-edge detectors. The previous-level register comes
    // out of reset high, so a button already held during reset must be
    // seen low once before it can produce an edge.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_edge
            always_ff @(posedge clock) begin
                if (reset) begin
                    btn_prev_reg[gi] <= 1'b1;
                    btn_edge_reg[gi] <= 1'b0;
                end else begin
                    btn_prev_reg[gi] <= btn_level[gi];
                    btn_edge_reg[gi] <= btn_level[gi] & ~btn_prev_reg[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Breakpoint compare. `resume` masks the compare for the first run
    // cycle after leaving IDLE so execution can restart from a PC that
    // equals the breakpoint address.
    // ------------------------------------------------------------------
`ifdef EXEC_CTRL_BREAKPOINT_EN
    assign bp_hit = bp_enable
                  && (cstate == FIRST_PHASE)
                  && (pc == bp_addr)
                  && !resume_reg
                  && ((state_reg == S_RUN) || (state_reg == S_DRAIN) || (state_reg == S_STEP_I));
`else
    assign bp_hit = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{bp_enable, bp_addr, pc, FIRST_PHASE, resume_reg};
`endif

    // The breakpoint gates run in the hit cycle itself, so the fetch at
    // bp_addr never executes.
    assign run_en = (state_reg != S_IDLE) && !bp_hit;
    assign retire = run_en && (cstate == LAST_PHASE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cause_reg      <= CAUSE_NONE;
            resume_reg     <= 1'b0;
            halt_reg       <= 1'b0;
            inst_count_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            cause_reg  <= cause_next;
            resume_reg <= resume_next;
            halt_reg   <= halt;
            if (retire) begin
                inst_count_reg <= inst_count_reg + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Halt acts through its registered copy, so run
    // drops one cycle after halt is first sampled.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cause_next  = cause_reg;
        resume_next = resume_reg;

        // The first cycle that actually advances the core consumes resume.
        if (run_en) begin
            resume_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                // Priority: run > step_inst > step_phase. A pending halt
                // swallows a run edge but never a step.
                if (btn_edge_reg[BTN_RUN]) begin
                    if (halt_reg) begin
                        cause_next = CAUSE_HALT;
                    end else begin
                        state_next  = S_RUN;
                        cause_next  = CAUSE_NONE;
                        resume_next = 1'b1;
                    end
                end else if (btn_edge_reg[BTN_STEP_I]) begin
                    state_next  = S_STEP_I;
                    cause_next  = CAUSE_NONE;
                    resume_next = 1'b1;
                end else if (btn_edge_reg[BTN_STEP_P]) begin
                    state_next  = S_STEP_P;
                    cause_next  = CAUSE_NONE;
                    resume_next = 1'b1;
                end
            end

            S_RUN: begin
                // Step edges are deliberately ignored while free-running.
                if (halt_reg) begin
                    state_next = S_IDLE;
                    cause_next = CAUSE_HALT;
                end else if (bp_hit) begin
                    state_next = S_IDLE;
                    cause_next = CAUSE_BREAK;
                end else if (btn_edge_reg[BTN_RUN]) begin
                    state_next = S_DRAIN;
                end
            end

            S_DRAIN, S_STEP_I: begin
                // Both finish the current instruction; run stays high
                // through the retire cycle inclusive.
                if (halt_reg) begin
                    state_next = S_IDLE;
                    cause_next = CAUSE_HALT;
                end else if (bp_hit) begin
                    state_next = S_IDLE;
                    cause_next = CAUSE_BREAK;
                end else if (retire) begin
                    state_next = S_IDLE;
                    cause_next = CAUSE_USER;
                end
            end

            S_STEP_P: begin
                // Exactly one run cycle per press.
                state_next = S_IDLE;
                cause_next = CAUSE_USER;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign run        = run_en;
    assign running    = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign stop_cause = cause_reg;
    assign inst_count = inst_count_reg;

endmodule
